uart_rx: RTL and testbench

- 8N1 UART receiver; the receive-side counterpart of the team's UART transmitter.
- Uses the same 16x oversampling baud tick scheme as the transmitter.
- Samples the serial line mid-bit, assembles one byte LSB first, and presents it with a one-cycle done strobe.
- Sits between the board RXD pin and the CPU I/O / switch-LED datapath.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry
// common to the receiver and transmitter.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detector.
// Edges are suppressed until the delayed copy holds a real line sample.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_rxd,
  output logic rxd_s,
  output logic fall
);

  logic [1:0] sync_reg;
  logic       prev_reg;
  logic [2:0] armed_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg  <= 2'b11;
      prev_reg  <= 1'b1;
      armed_reg <= 3'b000;
    end else begin
      sync_reg  <= {sync_reg[0], i_rxd};
      prev_reg  <= sync_reg[1];
      armed_reg <= {armed_reg[1:0], 1'b1};
    end
  end

  assign rxd_s = sync_reg[1];
  // A line held low through reset must not look like a start edge.
  assign fall  = armed_reg[2] & prev_reg & ~sync_reg[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clk_rx,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 RxDone,
  output logic                 o_frame_err,
  output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int MID_TICK = OVERSAMPLE / 2 - 1;
  localparam int TICK_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic rxd_s;
  logic fall;

  uart_rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .i_rxd (i_rxd),
    .rxd_s (rxd_s),
    .fall  (fall)
  );

  rx_state_t            state_reg, state_next;
  logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_data_reg;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 done_reg, done_next;
  logic                 ferr_reg, ferr_next;
  logic                 capture;
`ifdef UART_RX_PARITY_EN
  logic                 parity_reg, parity_next;
  logic                 perr_reg, perr_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      data_reg     <= '0;
      done_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= 1'b0;
      perr_reg     <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      data_reg     <= data_next;
      done_reg     <= done_next;
      ferr_reg     <= ferr_next;
`ifdef UART_RX_PARITY_EN
      parity_reg   <= parity_next;
      perr_reg     <= perr_next;
`endif
    end
  end

  // Each payload bit has its own enable so the byte assembles in place, LSB first.
  generate
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (reset) begin
          shift_data_reg[gi] <= 1'b0;
        end else if (capture && (bit_cnt_reg == BIT_W'(gi))) begin
          shift_data_reg[gi] <= rxd_s;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    data_next     = data_reg;
    done_next     = 1'b0;
    ferr_next     = 1'b0;
    capture       = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_next   = parity_reg;
    perr_next     = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (fall) begin
          state_next    = ST_START;
          tick_cnt_next = '0;
        end
      end
      ST_START: begin
        if (i_clk_rx) begin
          if (tick_cnt_reg == TICK_W'(MID_TICK)) begin
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
            state_next    = rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (i_clk_rx) begin
          if (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1)) begin
            capture       = 1'b1;
            tick_cnt_next = '0;
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (i_clk_rx) begin
          if (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1)) begin
            parity_next   = rxd_s;
            tick_cnt_next = '0;
            state_next    = ST_STOP;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (i_clk_rx) begin
          if (tick_cnt_reg == TICK_W'(OVERSAMPLE - 1)) begin
            tick_cnt_next = '0;
            state_next    = ST_IDLE;
            if (rxd_s) begin
              done_next = 1'b1;
              data_next = shift_data_reg;
`ifdef UART_RX_PARITY_EN
              // Even parity: the parity bit must equal the XOR of the payload.
              perr_next = (parity_reg != (^shift_data_reg));
`endif
            end else begin
              ferr_next = 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next    = ST_IDLE;
        tick_cnt_next = '0;
      end
    endcase
  end

  assign o_data      = data_reg;
  assign RxDone      = done_reg;
  assign o_frame_err = ferr_reg;
  assign o_busy      = (state_reg != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx; parity scenarios are built
// only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_clk_rx = 1'b0;
  logic       i_rxd = 1'b1;
  logic [7:0] o_data;
  logic       RxDone;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  int checks = 0;
  int errors = 0;

  int done_cnt = 0;
  int ferr_cnt = 0;
  int excl_cnt = 0;
  int perr_cnt = 0;
  int perr_with_done_cnt = 0;
  logic [1:0] tick_div = 2'd0;

  uart_rx dut (
    .clk         (clk),
    .reset       (reset),
    .i_clk_rx    (i_clk_rx),
    .i_rxd       (i_rxd),
    .o_data      (o_data),
    .RxDone      (RxDone),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  // One oversample tick every 4 clocks.
  always @(negedge clk) begin
    tick_div = tick_div + 2'd1;
    i_clk_rx = (tick_div == 2'd0);
  end

  always @(negedge clk) begin
    if (RxDone) done_cnt++;
    if (o_frame_err) ferr_cnt++;
    if (RxDone && o_frame_err) excl_cnt++;
`ifdef UART_RX_PARITY_EN
    if (o_parity_err) perr_cnt++;
    if (o_parity_err && RxDone) perr_with_done_cnt++;
`endif
  end

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      @(posedge clk);
      while (!i_clk_rx && guard < 100) begin
        @(posedge clk);
        guard++;
      end
      if (guard >= 100) begin
        errors++;
        $display("FAIL tick_timeout got no tick want tick within 100 clk");
      end
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic use_par, input logic par_b);
    i_rxd = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 8; b++) begin
      i_rxd = d[b];
      wait_ticks(16);
    end
    if (use_par) begin
      i_rxd = par_b;
      wait_ticks(16);
    end
    i_rxd = stop_b;
    wait_ticks(16);
    $display("frame sent 0x%02h stop=%0b o_data=0x%02h done=%0d ferr=%0d",
             d, stop_b, o_data, done_cnt, ferr_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", o_busy); end
    checks++; if (RxDone !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", RxDone); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL rst_ferr got %b want 0", o_frame_err); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data got %02h want 00", o_data); end
    reset = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", o_busy); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL idle_done got %0d want 0", done_cnt); end
    checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL idle_ferr got %0d want 0", ferr_cnt); end
    $display("reset and 1000 idle clk done");
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    wait_ticks(4);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL basic_ferr got %0d want 0", ferr_cnt - f0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %02h want a5", o_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", o_busy); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    i_rxd = 1'b0;
    wait_ticks(4);
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_start got %b want 1", o_busy); end
    i_rxd = 1'b1;
    wait_ticks(12);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", o_busy); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL glitch_done got %0d want 0", done_cnt - d0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL glitch_data got %02h want a5", o_data); end
    $display("glitch 4 ticks busy=%b o_data=0x%02h", o_busy, o_data);
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    int f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got %0d want 1", ferr_cnt - f0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL ferr_done got %0d want 0", done_cnt - d0); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL ferr_data got %02h want a5", o_data); end
    wait_ticks(40);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ferr_low_busy got %b want 0", o_busy); end
    checks++; if (ferr_cnt - f0 !== 1 || done_cnt - d0 !== 0) begin
      errors++; $display("FAIL ferr_low_strobe got ferr=%0d done=%0d want 1 0", ferr_cnt - f0, done_cnt - d0);
    end
    i_rxd = 1'b1;
    wait_ticks(16);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    checks++; if (o_data !== 8'h3C) begin errors++; $display("FAIL ferr_recover got %02h want 3c", o_data); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL b2b_first got %02h want 00", o_data); end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    checks++; if (o_data !== 8'hFF) begin errors++; $display("FAIL b2b_second got %02h want ff", o_data); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt - d0); end
    checks++; if (excl_cnt !== 0) begin errors++; $display("FAIL excl got %0d want 0", excl_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d = 8'h5A;
    int d0;
    int f0;
    i_rxd = 1'b0;
    wait_ticks(16);
    for (int b = 0; b < 3; b++) begin
      i_rxd = d[b];
      wait_ticks(16);
    end
    i_rxd = d[3];
    wait_ticks(8);
    d0 = done_cnt;
    f0 = ferr_cnt;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", o_busy); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL midrst_data got %02h want 00", o_data); end
    i_rxd = 1'b1;
    wait_ticks(32);
    checks++; if (done_cnt - d0 !== 0 || ferr_cnt - f0 !== 0) begin
      errors++; $display("FAIL midrst_strobe got done=%0d ferr=%0d want 0 0", done_cnt - d0, ferr_cnt - f0);
    end
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    checks++; if (o_data !== 8'h81) begin errors++; $display("FAIL midrst_next got %02h want 81", o_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int p0 = perr_cnt;
    int b0 = perr_with_done_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL par_bad got %0d want 1", perr_cnt - p0); end
    checks++; if (perr_with_done_cnt - b0 !== 1) begin errors++; $display("FAIL par_with_done got %0d want 1", perr_with_done_cnt - b0); end
    checks++; if (o_data !== 8'h07) begin errors++; $display("FAIL par_data got %02h want 07", o_data); end
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b1);
    checks++; if (perr_cnt - p0 !== 0) begin errors++; $display("FAIL par_good got %0d want 0", perr_cnt - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
